// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: ctrl codes, slice op field, FSM states.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic ctrl_supported(input logic [3:0] c);
    return (c == CTRL_AND) || (c == CTRL_OR) || (c == CTRL_ADD) ||
           (c == CTRL_SUB) || (c == CTRL_SLT) || (c == CTRL_NOR);
  endfunction

  function automatic logic ctrl_is_arith(input logic [3:0] c);
    return (c == CTRL_ADD) || (c == CTRL_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice: operand inversion, full adder, and AND/OR/sum/less result mux.
import alu_pkg::*;

module alu_slice (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic       a_invert_i,
  input  logic       b_invert_i,
  input  logic [1:0] op_i,
  input  logic       less_i,
  output logic       result_o,
  output logic       cout_o,
  output logic       set_o,
  output logic       overflow_o
);

  logic a_eff;
  logic b_eff;
  logic sum;

  assign a_eff      = a_i ^ a_invert_i;
  assign b_eff      = b_i ^ b_invert_i;
  assign sum        = a_eff ^ b_eff ^ cin_i;
  assign cout_o     = (a_eff & b_eff) | (a_eff & cin_i) | (b_eff & cin_i);
  assign set_o      = sum;
  // Only meaningful at the MSB: signed overflow is carry-in differing from carry-out.
  assign overflow_o = cin_i ^ cout_o;

  always_comb begin
    result_o = 1'b0;
    case (op_i)
      OP_AND:  result_o = a_eff & b_eff;
      OP_OR:   result_o = a_eff | b_eff;
      OP_ADD:  result_o = sum;
      OP_LESS: result_o = less_i;
      default: result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one alu_slice iterated WIDTH cycles with a registered ripple carry.
// Optional abort input enabled by defining ALU_SERIAL_ABORT_EN.
import alu_pkg::*;

module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic             abort,
`endif
  output state_t           dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready/valid are decoded from the state register only, never from the partner's signal.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             a_inv_q, a_inv_d;
  logic             b_inv_q, b_inv_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             slice_res;
  logic             slice_cout;
  logic             slice_set;
  logic             slice_ovf;
  logic [1:0]       slice_op;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] final_res;

  // SLT runs as a subtraction; the less-than bit is formed from the MSB afterwards.
  assign slice_op = (ctrl_q == CTRL_SLT) ? OP_ADD : op_q;
  assign shifted  = {slice_res, result_q[WIDTH-1:1]};

  alu_slice u_slice (
    .a_i        (src1_q[cnt_q]),
    .b_i        (src2_q[cnt_q]),
    .cin_i      (carry_q),
    .a_invert_i (a_inv_q),
    .b_invert_i (b_inv_q),
    .op_i       (slice_op),
    .less_i     (1'b0),
    .result_o   (slice_res),
    .cout_o     (slice_cout),
    .set_o      (slice_set),
    .overflow_o (slice_ovf)
  );

  always_comb begin
    state_d   = state_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    ctrl_d    = ctrl_q;
    a_inv_d   = a_inv_q;
    b_inv_d   = b_inv_q;
    op_d      = op_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    final_res = shifted;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          src1_d  = src1;
          src2_d  = src2;
          ctrl_d  = ctrl;
          a_inv_d = ctrl[3];
          b_inv_d = ctrl[2];
          op_d    = ctrl[1:0];
          carry_d = ctrl[2];
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        result_d = shifted;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!ctrl_supported(ctrl_q)) begin
            final_res = '0;
            cout_d    = 1'b0;
            ovf_d     = 1'b0;
          end else if (ctrl_q == CTRL_SLT) begin
            final_res = {{(WIDTH-1){1'b0}}, slice_set ^ slice_ovf};
            cout_d    = slice_cout;
            ovf_d     = 1'b0;
          end else begin
            final_res = shifted;
            cout_d    = slice_cout;
            ovf_d     = ctrl_is_arith(ctrl_q) ? slice_ovf : 1'b0;
          end
          result_d = final_res;
          zero_d   = (final_res == '0);
          state_d  = DONE;
        end
`ifdef ALU_SERIAL_ABORT_EN
        if (abort) begin
          result_d = '0;
          zero_d   = 1'b0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
`endif
      end

      DONE: begin
        if (done_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      ctrl_q   <= '0;
      a_inv_q  <= 1'b0;
      b_inv_q  <= 1'b0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      ctrl_q   <= ctrl_d;
      a_inv_q  <= a_inv_d;
      b_inv_q  <= b_inv_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial ALU sequencer that drives one 1-bit ALU slice for WIDTH cycles to execute a full-width operation. It accepts operands and a 4-bit ALU control code over a valid/ready handshake and carries the ripple carry between cycles in a register. It produces the full-width result plus zero/cout/overflow flags over a second valid/ready handshake. It is the area-minimal alternative to the ripple-carry ALU in the lab datapath.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  operation request
- start_ready  out  1  block idle and able to accept
- ctrl  in  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- src1  in  WIDTH  operand A
- src2  in  WIDTH  operand B
- done_valid  out  1  result/flags valid
- done_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- cout  out  1  carry out of bit WIDTH-1
- overflow  out  1  signed overflow, ADD/SUB only

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: start_ready=1. When start_valid=1, the block latches src1, src2 and the decoded controls, then goes to RUN:
  - A_invert = ctrl[3]
  - B_invert = ctrl[2]
  - op = ctrl[1:0]
  - carry register = ctrl[2]
  - bit counter = 0
- RUN, one bit per cycle:
  - The slice receives src1[cnt], src2[cnt], the carry register and the decoded controls.
  - For SLT, the slice op is forced to 10 (subtract) during RUN.
  - Each cycle: the slice result shifts into result[WIDTH-1] (shift-right register), carry register <= slice cout, cnt++.
- RUN at cnt == WIDTH-1:
  - Capture cout and the slice overflow.
  - The captured overflow is forced to 0 unless ctrl is ADD or SUB.
  - For SLT: result <= {WIDTH-1 zeros, sum_msb ^ ovf_msb}. This is the signed-correct less-than, and the overflow output is 0.
  - Go to DONE.
- DONE: done_valid=1. result and flags are held stable until done_ready=1, then the block returns to IDLE.
- Unsupported ctrl codes: still take WIDTH cycles; result=0, cout=0, overflow=0, zero=1.
- zero is registered, computed from the final result.
- start_valid is ignored outside IDLE (start_ready=0 in RUN and DONE).

## Timing
- Reset values: start_ready=1, done_valid=0, result=0, zero=0, cout=0, overflow=0; carry register, counter and operands are cleared.
- Accept happens at the edge E0 where start_valid & start_ready. Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- done_valid rises after E_WIDTH, so latency is WIDTH cycles from accept.
- Throughput: one operation per WIDTH+2 cycles minimum.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- done_ready=1 together with start_valid=1 in DONE: the block goes to IDLE at that edge. The new request is accepted at the following edge; there is no bypass.
- Changes on src1/src2/ctrl after accept have no effect.
- rst_n asserted in any state, including mid-RUN: the block immediately enters IDLE with the reset values above. The partial result is discarded.

## Configuration
- Macro: ALU_SERIAL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN returns the block to IDLE at the next edge. done_valid is never raised for that operation, and result/flags are cleared to 0.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port; RUN always completes.

## Structure
- Shared package alu_pkg holds:
  - ctrl code constants: CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR
  - FSM state encoding: IDLE, RUN, DONE
  - op field constants: OP_AND, OP_OR, OP_ADD, OP_LESS
- One sub-module, alu_slice: a combinational 1-bit slice providing:
  - operand inversion
  - AND/OR/sum/less mux
  - full adder with set and overflow outputs
- alu_serial_seq instantiates alu_slice once. All sequencing, the carry register and the result shift register live in alu_serial_seq.

## Test plan
- ADD: 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0, zero=0; done_valid rises exactly 32 cycles after accept.
- SUB: 0x00000005 - 0x00000005 -> result 0, zero=1, cout=1, overflow=0. SUB 0x80000000 - 0x00000001 -> overflow=1.
- SLT, including the overflow case:
  - 0xFFFFFFFF vs 0x00000001 -> result 0x00000001
  - 0x7FFFFFFF vs 0x80000000 -> result 0x00000000
  - 0x80000000 vs 0x7FFFFFFF -> result 0x00000001
- Logic: AND 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000; OR -> 0xFFF0FFF0; NOR 0xF0F0F0F0, 0x0F0F0F0F -> 0x00000000, zero=1.
- Backpressure: hold done_ready=0 for 10 cycles in DONE and pulse start_valid with new operands -> result/flags stable, start_ready=0, request not taken. Release done_ready -> new request accepted one cycle later.
- Mid-operation reset: assert rst_n=0 after bit 10 of an ADD -> all outputs at reset values, start_ready=1; the next operation completes correctly. With ALU_SERIAL_ABORT_EN: abort at bit 10 -> IDLE next cycle, no done_valid.
